sm_key_debouncer: RTL and testbench

//   Conditions the raw board push-buttons/switches (key_sw) before the board top consumes them.

---
 rtl/sm_key_debouncer.sv | 53 +++++
 tb/tb_sm_key_debouncer.sv | 128 ++++++++++++
 2 files changed

// File: rtl/sm_key_debouncer.sv
// sm_key_debouncer: per-key 2-FF synchronizer and stable-count debouncer with press/release strobes and a press-toggled latch
module sm_key_debouncer #(
  parameter int KEYS       = 4,
  parameter int DEBOUNCE   = 50000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [KEYS-1:0] key_raw,
  output logic [KEYS-1:0] key_level,
  output logic [KEYS-1:0] key_press,
  output logic [KEYS-1:0] key_release,
  output logic [KEYS-1:0] key_toggle
);
  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);
  localparam logic [KEYS-1:0] RELEASED = {KEYS{ACTIVE_LOW != 0}};
  logic [KEYS-1:0] r_s1, r_s2, r_level, r_press, r_release, r_toggle, w_n;
  logic [CNT_W-1:0] r_cnt [KEYS];
  always_comb w_n = (ACTIVE_LOW != 0) ? ~r_s2 : r_s2;
  // Sync stages reset to the released level so a held key is seen as a fresh press after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1      <= RELEASED;
      r_s2      <= RELEASED;
      r_level   <= '0;
      r_press   <= '0;
      r_release <= '0;
      r_toggle  <= '0;
      for (int k = 0; k < KEYS; k++) r_cnt[k] <= '0;
    end else begin
      r_s1 <= key_raw;
      r_s2 <= r_s1;
      for (int k = 0; k < KEYS; k++) begin
        r_press[k]   <= 1'b0;
        r_release[k] <= 1'b0;
        if (w_n[k] == r_level[k]) r_cnt[k] <= '0;
        else if (r_cnt[k] != CNT_MAX) r_cnt[k] <= r_cnt[k] + 1'b1;
        else begin
          r_cnt[k]     <= '0;
          r_level[k]   <= w_n[k];
          r_press[k]   <= w_n[k];
          r_release[k] <= ~w_n[k];
          r_toggle[k]  <= r_toggle[k] ^ w_n[k];
        end
      end
    end
  end
  assign key_level   = r_level;
  assign key_press   = r_press;
  assign key_release = r_release;
  assign key_toggle  = r_toggle;
endmodule

// File: tb/tb_sm_key_debouncer.sv
// tb_sm_key_debouncer: directed key stimulus with a scoreboard of expected strobe events checked by a monitor
module tb_sm_key_debouncer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] key_raw = 4'hF;
  logic [3:0] key_level, key_press, key_release, key_toggle;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  typedef struct {
    int cyc;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] level;
    logic [3:0] tog;
  } ev_t;
  ev_t sb[$];
  sm_key_debouncer #(.KEYS(4), .DEBOUNCE(4), .ACTIVE_LOW(1)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key_raw(key_raw),
    .key_level(key_level),
    .key_press(key_press),
    .key_release(key_release),
    .key_toggle(key_toggle)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  // A raw change driven at a negedge is accepted six edges later (2 sync + DEBOUNCE count edges).
  task automatic expect_ev(input logic [3:0] p, input logic [3:0] r, input logic [3:0] l, input logic [3:0] t);
    ev_t e;
    e.cyc = cyc + 6;
    e.press = p;
    e.rel = r;
    e.level = l;
    e.tog = t;
    sb.push_back(e);
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic drive(input logic [3:0] v);
    @(negedge clk);
    key_raw = v;
  endtask
  always @(negedge clk) begin
    if (key_press != 4'h0 || key_release != 4'h0) begin
      if (sb.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL unexpected_strobe: press=%h release=%h at cycle %0d", key_press, key_release, cyc);
      end else begin
        ev_t e;
        e = sb.pop_front();
        check("event_cycle", cyc, e.cyc);
        check("key_press", {28'h0, key_press}, {28'h0, e.press});
        check("key_release", {28'h0, key_release}, {28'h0, e.rel});
        check("key_level", {28'h0, key_level}, {28'h0, e.level});
        check("key_toggle", {28'h0, key_toggle}, {28'h0, e.tog});
      end
    end
  end
  initial begin
    idle(2);
    check("rst_level", {28'h0, key_level}, 32'h0);
    check("rst_press", {28'h0, key_press}, 32'h0);
    check("rst_release", {28'h0, key_release}, 32'h0);
    check("rst_toggle", {28'h0, key_toggle}, 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      idle(1);
      check("idle_level", {28'h0, key_level}, 32'h0);
    end
    drive(4'b1101);
    expect_ev(4'b0010, 4'b0000, 4'b0010, 4'b0010);
    idle(10);
    drive(4'b1001);
    idle(2);
    drive(4'b1101);
    drive(4'b1001);
    idle(2);
    drive(4'b1101);
    idle(10);
    check("bounce_level", {28'h0, key_level}, 32'h2);
    drive(4'b1100);
    expect_ev(4'b0001, 4'b0000, 4'b0011, 4'b0011);
    idle(10);
    drive(4'b1101);
    expect_ev(4'b0000, 4'b0001, 4'b0010, 4'b0011);
    idle(10);
    drive(4'b1100);
    expect_ev(4'b0001, 4'b0000, 4'b0011, 4'b0010);
    idle(10);
    drive(4'b1101);
    expect_ev(4'b0000, 4'b0001, 4'b0010, 4'b0010);
    idle(10);
    drive(4'b1111);
    expect_ev(4'b0000, 4'b0010, 4'b0000, 4'b0010);
    idle(10);
    drive(4'b0000);
    expect_ev(4'b1111, 4'b0000, 4'b1111, 4'b1101);
    idle(10);
    drive(4'b1111);
    expect_ev(4'b0000, 4'b1111, 4'b0000, 4'b1101);
    idle(10);
    drive(4'b0111);
    idle(3);
    rst_n = 1'b0;
    idle(2);
    check("midrst_level", {28'h0, key_level}, 32'h0);
    check("midrst_toggle", {28'h0, key_toggle}, 32'h0);
    check("midrst_press", {28'h0, key_press}, 32'h0);
    rst_n = 1'b1;
    expect_ev(4'b1000, 4'b0000, 4'b1000, 4'b1000);
    idle(12);
    check("final_level", {28'h0, key_level}, 32'h8);
    check("pending_events", sb.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
